// File: rtl/clk_div_multi_if.sv
// Control and output bundle for the multi-channel clock divider.
// The master side configures the channels; the slave side is the divider.
interface clk_div_multi_if #(
    parameter int WIDTH    = 24,
    parameter int CHANNELS = 2,
    parameter int SEL_W    = 1
);
    logic [CHANNELS-1:0] en;
    logic                load;
    logic [SEL_W-1:0]    ch_sel;
    logic [WIDTH-1:0]    div_in;
    logic [WIDTH-1:0]    high_in;
    logic [CHANNELS-1:0] clk_out;
    logic [CHANNELS-1:0] tick;

    modport master (
        output en, load, ch_sel, div_in, high_in,
        input  clk_out, tick
    );

    modport slave (
        input  en, load, ch_sel, div_in, high_in,
        output clk_out, tick
    );
endinterface

// File: rtl/clk_div_multi.sv
// Independent programmable clock dividers with shadowed (period, high-time) pairs
// that take effect only at a period boundary, when disabled, or when the period is degenerate.
module clk_div_multi #(
    parameter int               WIDTH        = 24,
    parameter int               CHANNELS     = 2,
    parameter int               SEL_W        = 1,
    parameter logic [WIDTH-1:0] DEFAULT_DIV  = WIDTH'(24'd12_000_000),
    parameter logic [WIDTH-1:0] DEFAULT_HIGH = WIDTH'(24'd6_000_000)
) (
    input  logic           clk_in,
    input  logic           rst,
    clk_div_multi_if.slave bus
);

    logic [CHANNELS-1:0] clk_out_vec;
    logic [CHANNELS-1:0] tick_vec;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [WIDTH-1:0] cnt_q, cnt_d;
            logic [WIDTH-1:0] act_div_q, act_div_d;
            logic [WIDTH-1:0] act_high_q, act_high_d;
            logic [WIDTH-1:0] shd_div_q, shd_div_d;
            logic [WIDTH-1:0] shd_high_q, shd_high_d;
            logic             pend_q, pend_d;
            logic             clk_out_q, clk_out_d;
            logic             tick_q, tick_d;
            logic             load_hit;
            logic             pend_eff;
            logic             short_p;
            logic             wrap;
            logic             apply;

            always_comb begin
                // A load on this very edge counts as already pending so it can apply immediately.
                load_hit   = bus.load && (bus.ch_sel == SEL_W'(gi));
                shd_div_d  = load_hit ? bus.div_in  : shd_div_q;
                shd_high_d = load_hit ? bus.high_in : shd_high_q;
                pend_eff   = pend_q || load_hit;

                short_p = (act_div_q < WIDTH'(2));
                wrap    = (cnt_q == act_div_q - WIDTH'(1));
                apply   = pend_eff && (!bus.en[gi] || short_p || wrap);

                act_div_d  = apply ? shd_div_d  : act_div_q;
                act_high_d = apply ? shd_high_d : act_high_q;
                pend_d     = pend_eff && !apply;

                cnt_d     = '0;
                clk_out_d = 1'b0;
                tick_d    = 1'b0;
                if (bus.en[gi] && !short_p) begin
                    cnt_d     = wrap ? '0 : cnt_q + WIDTH'(1);
                    clk_out_d = (cnt_q < act_high_q);
                    tick_d    = wrap;
                end
            end

            always_ff @(posedge clk_in or negedge rst) begin
                if (!rst) begin
                    cnt_q      <= '0;
                    act_div_q  <= DEFAULT_DIV;
                    act_high_q <= DEFAULT_HIGH;
                    shd_div_q  <= DEFAULT_DIV;
                    shd_high_q <= DEFAULT_HIGH;
                    pend_q     <= 1'b0;
                    clk_out_q  <= 1'b0;
                    tick_q     <= 1'b0;
                end else begin
                    cnt_q      <= cnt_d;
                    act_div_q  <= act_div_d;
                    act_high_q <= act_high_d;
                    shd_div_q  <= shd_div_d;
                    shd_high_q <= shd_high_d;
                    pend_q     <= pend_d;
                    clk_out_q  <= clk_out_d;
                    tick_q     <= tick_d;
                end
            end

            assign clk_out_vec[gi] = clk_out_q;
            assign tick_vec[gi]    = tick_q;
        end
    endgenerate

    assign bus.clk_out = clk_out_vec;
    assign bus.tick    = tick_vec;

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: a time-indexed period model checked every cycle,
// plus literal waveform expectations for each configuration scenario.
module tb_clk_div_multi;

    localparam int W  = 8;
    localparam int CH = 2;
    localparam int SW = 2;

    logic clk_in;
    logic rst;

    clk_div_multi_if #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW)) bus ();

    clk_div_multi #(
        .WIDTH(W), .CHANNELS(CH), .SEL_W(SW),
        .DEFAULT_DIV(8'd4), .DEFAULT_HIGH(8'd2)
    ) dut (
        .clk_in(clk_in),
        .rst   (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: each channel remembers the edge index at which its current period began.
    bit          armed = 0;
    int          edge_n = 0;
    int          start_e[CH];
    int          per[CH], hi[CH], s_per[CH], s_hi[CH];
    bit          pend[CH];
    logic [CH-1:0] exp_clk = '0;
    logic [CH-1:0] exp_tick = '0;

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            per[c] = 4; hi[c] = 2; s_per[c] = 4; s_hi[c] = 2;
            pend[c] = 0;
            start_e[c] = edge_n;
        end
        exp_clk = '0;
        exp_tick = '0;
        armed = 1;
    endtask

    task automatic model_step();
        for (int c = 0; c < CH; c++) begin
            if (bus.load && int'(bus.ch_sel) == c) begin
                s_per[c] = int'(bus.div_in);
                s_hi[c]  = int'(bus.high_in);
                pend[c]  = 1;
            end
            if (!bus.en[c] || per[c] < 2) begin
                exp_clk[c]  = 1'b0;
                exp_tick[c] = 1'b0;
                start_e[c]  = edge_n + 1;
                if (pend[c]) begin per[c] = s_per[c]; hi[c] = s_hi[c]; pend[c] = 0; end
            end else begin
                int pos;
                pos = edge_n - start_e[c];
                exp_clk[c]  = (pos < hi[c]);
                exp_tick[c] = (pos == per[c] - 1);
                if (pos == per[c] - 1) begin
                    start_e[c] = edge_n + 1;
                    if (pend[c]) begin per[c] = s_per[c]; hi[c] = s_hi[c]; pend[c] = 0; end
                end
            end
        end
        edge_n++;
    endtask

    initial forever begin
        @(negedge rst);
        model_reset();
    end

    initial forever begin
        @(posedge clk_in);
        if (armed && rst) model_step();
    end

    initial forever begin
        @(negedge clk_in);
        if (armed) begin
            chk("model_clk_out", 32'(bus.clk_out), 32'(exp_clk));
            chk("model_tick", 32'(bus.tick), 32'(exp_tick));
        end
    end

    task automatic load_ch(input int sel, input int d, input int h);
        bus.load = 1'b1;
        bus.ch_sel = SW'(sel);
        bus.div_in = W'(d);
        bus.high_in = W'(h);
        @(negedge clk_in);
        bus.load = 1'b0;
    endtask

    task automatic skip(input int edges);
        repeat (edges) @(negedge clk_in);
    endtask

    task automatic count(input int edges, input int c, output int ones, output int ticks);
        ones = 0;
        ticks = 0;
        repeat (edges) begin
            @(negedge clk_in);
            ones  += int'(bus.clk_out[c]);
            ticks += int'(bus.tick[c]);
        end
    endtask

    task automatic wait_tick0(input int maxc);
        int k;
        k = 0;
        while (bus.tick[0] !== 1'b1 && k < maxc) begin
            @(negedge clk_in);
            k++;
        end
        chk("wait_tick0_seen", 32'(bus.tick[0]), 32'd1);
    endtask

    initial begin
        int ones, ticks;
        bit exp31_c[9] = '{1, 0, 0, 1, 0, 0, 0, 0, 0};
        bit exp31_t[9] = '{0, 0, 1, 0, 0, 0, 0, 0, 1};
        bit exp35_c[10] = '{1, 1, 0, 0, 1, 1, 1, 0, 0, 1};
        bit exp35_t[10] = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
        bit pat_c[4] = '{1, 1, 0, 0};
        bit pat_t[4] = '{0, 0, 0, 1};

        rst = 1'b1;
        bus.en = '0;
        bus.load = 1'b0;
        bus.ch_sel = '0;
        bus.div_in = '0;
        bus.high_in = '0;

        // Asynchronous reset: outputs must clear before any clock edge.
        #3 rst = 1'b0;
        #1;
        chk("reset_clk_out", 32'(bus.clk_out), 32'd0);
        chk("reset_tick", 32'(bus.tick), 32'd0);
        skip(2);
        rst = 1'b1;
        bus.en = 2'b11;

        // Default 4/2 on both channels.
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk_in);
            chk("default_clk_out", 32'(bus.clk_out), ((k - 1) % 4 < 2) ? 32'd3 : 32'd0);
            chk("default_tick", 32'(bus.tick), (k % 4 == 0) ? 32'd3 : 32'd0);
        end

        // Load ch1 6/1 while it sits at cnt=1.
        @(negedge clk_in);
        bus.load = 1'b1; bus.ch_sel = 2'd1; bus.div_in = 8'd6; bus.high_in = 8'd1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk_in);
            if (k == 0) bus.load = 1'b0;
            chk("reload_ch1_clk", 32'(bus.clk_out[1]), 32'(exp31_c[k]));
            chk("reload_ch1_tick", 32'(bus.tick[1]), 32'(exp31_t[k]));
            chk("reload_ch0_clk", 32'(bus.clk_out[0]), 32'(pat_c[(k + 1) % 4]));
        end

        // H >= P, H = 0, P < 2.
        load_ch(1, 3, 5);
        skip(8);
        count(6, 1, ones, ticks);
        chk("h_ge_p_high_count", ones, 6);
        chk("h_ge_p_tick_count", ticks, 2);
        load_ch(1, 3, 0);
        skip(4);
        count(6, 1, ones, ticks);
        chk("h_zero_high_count", ones, 0);
        chk("h_zero_tick_count", ticks, 2);
        load_ch(1, 1, 1);
        skip(4);
        count(6, 1, ones, ticks);
        chk("p_one_high_count", ones, 0);
        chk("p_one_tick_count", ticks, 0);

        // Restore ch1, then reload it and issue an out-of-range load on the next cycle.
        bus.load = 1'b1; bus.ch_sel = 2'd1; bus.div_in = 8'd4; bus.high_in = 8'd2;
        @(negedge clk_in);
        bus.div_in = 8'd5; bus.high_in = 8'd3;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_in);
            if (k == 0) begin bus.ch_sel = 2'd3; bus.div_in = 8'd2; bus.high_in = 8'd1; end
            if (k == 1) bus.load = 1'b0;
            chk("bad_sel_ch1_clk", 32'(bus.clk_out[1]), 32'(exp35_c[k]));
            chk("bad_sel_ch1_tick", 32'(bus.tick[1]), 32'(exp35_t[k]));
        end

        // Largest period the counter width allows.
        load_ch(1, 255, 200);
        skip(6);
        count(510, 1, ones, ticks);
        chk("p_max_high_count", ones, 400);
        chk("p_max_tick_count", ticks, 2);

        // Disable ch0 at cnt=2, then re-enable.
        wait_tick0(8);
        skip(2);
        bus.en[0] = 1'b0;
        @(negedge clk_in);
        chk("disable_clk0", 32'(bus.clk_out[0]), 32'd0);
        chk("disable_tick0", 32'(bus.tick[0]), 32'd0);
        @(negedge clk_in);
        chk("disable_tick0_hold", 32'(bus.tick[0]), 32'd0);
        bus.en[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_in);
            chk("reenable_clk0", 32'(bus.clk_out[0]), 32'(pat_c[k]));
            chk("reenable_tick0", 32'(bus.tick[0]), 32'(pat_t[k]));
        end

        // Reset mid-period with a pending ch0 load.
        wait_tick0(8);
        bus.load = 1'b1; bus.ch_sel = 2'd0; bus.div_in = 8'd7; bus.high_in = 8'd3;
        @(negedge clk_in);
        bus.load = 1'b0;
        chk("pre_reset_clk0", 32'(bus.clk_out[0]), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("midrun_reset_clk_out", 32'(bus.clk_out), 32'd0);
        chk("midrun_reset_tick", 32'(bus.tick), 32'd0);
        skip(2);
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_in);
            chk("post_reset_clk_out", 32'(bus.clk_out), pat_c[k % 4] ? 32'd3 : 32'd0);
            chk("post_reset_tick", 32'(bus.tick), pat_t[k % 4] ? 32'd3 : 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
